dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data-memory responder serving the pipeline's MEM stage: accepts one load/store request at a time over a valid/ready handshake, inserts a programmable number of wait states, then returns read data or write completion with a one-cycle response strobe. Replaces the zero-latency data memory so the core can be exercised against realistic memory latency. Supports byte, word and doubleword accesses on the 64-bit datapath, big-endian byte order.

## Interface
Parameters:
- ADDR_W, 10: byte-address width; storage is 2**ADDR_W bytes.
- WAIT_CYCLES, 2: wait states between accept and response (0..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  byte access.
- req_double  in  1  doubleword access (neither flag = word).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data, right-justified.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  64  load data, valid with rsp_valid.
- rsp_err  out  1  access rejected, valid with rsp_valid.
- busy  out  1  request in flight (state != IDLE).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch write/size/addr/wdata; go WAIT (load counter WAIT_CYCLES-1), or RESP directly if WAIT_CYCLES=0.
- WAIT: decrement counter; at 0 go RESP.
- RESP: rsp_valid=1 one cycle; always return to IDLE. No response backpressure.
- Store commits to the array on the WAIT->RESP (or IDLE->RESP) edge; never partially.
- Size/alignment: byte any address; word requires addr[1:0]=0; double requires addr[2:0]=0. Both req_byte and req_double high is illegal.
- Error (misaligned, illegal size, or access extending past top of array): no write, rsp_rdata=0, rsp_err=1.
- Load result: byte sign-extended to 64; word in [31:0], [63:32]=0; double full 64 bits. Byte at lowest address is most significant.
- Store uses req_wdata[7:0] / [31:0] / [63:0] by size.
- rsp_rdata/rsp_err hold their value outside RESP; consumers sample only on rsp_valid.
- Storage array is not reset; contents after power-up undefined.

## Timing
- Reset values: req_ready=1 (after reset release), rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state IDLE. During reset req_ready=0.
- Accept at edge T (req_valid & req_ready); rsp_valid high in cycle T+WAIT_CYCLES+1; req_ready high again at T+WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Request inputs ignored outside IDLE; req_valid may stay high across a transaction without double-accept.
- Reset mid-transaction: abort immediately, no store committed, no rsp_valid.
- Load following a store to the same address returns the new data (store committed before the load is accepted).

## Structure
- Shared package: size enum (SZ_BYTE, SZ_WORD, SZ_DOUBLE), state enum (IDLE, WAIT, RESP), alignment-check function.
- One sub-module: dmem_lane_align — combinational byte-lane extract (load, with sign/zero extension) and merge (store) for a given size and address; keeps the FSM file small.

## Test plan
- Reset then word store 0xDEADBEEF at 0x010, word load 0x010 -> rsp_valid at accept+3 (WAIT_CYCLES=2), rsp_rdata=0x00000000DEADBEEF, rsp_err=0.
- Byte load at 0x010 after above -> rsp_rdata=0xFFFFFFFFFFFFFFDE; byte load 0x013 -> 0xFFFFFFFFFFFFFFEF.
- Double store 0x0123456789ABCDEF at 0x020, word load 0x024 -> 0x0000000089ABCDEF.
- Word load at 0x012 and double store at 0x024 -> rsp_err=1, rsp_rdata=0; subsequent double load 0x020 still 0x0123456789ABCDEF.
- rst_n pulsed low during WAIT of store 0x55 to 0x030 (previously 0x00) -> no rsp_valid, byte load 0x030 returns 0.
- WAIT_CYCLES=0 build, req_valid held high for 3 back-to-back loads -> exactly 3 rsp_valid pulses, each 1 cycle after accept, req_ready low on each RESP cycle.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_responder_pkg;

   typedef enum logic [1:0] {SZ_BYTE, SZ_WORD, SZ_DOUBLE} size_e;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   function automatic logic is_aligned(input size_e size, input logic [2:0] lsb);
      logic ok;
      case (size)
         SZ_BYTE:   ok = 1'b1;
         SZ_WORD:   ok = (lsb[1:0] == 2'b00);
         SZ_DOUBLE: ok = (lsb == 3'b000);
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] size_bytes(input size_e size);
      logic [3:0] n;
      case (size)
         SZ_BYTE:   n = 4'd1;
         SZ_WORD:   n = 4'd4;
         SZ_DOUBLE: n = 4'd8;
         default:   n = 4'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian byte-lane extract (load) and merge (store) over an 8-byte window
// whose most significant byte is the one at the access address.
module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  size_e       size,
   input  logic [63:0] rwin,
   input  logic [63:0] wdata,
   output logic [63:0] rdata,
   output logic [63:0] wwin,
   output logic [7:0]  be
);

   // be[i] enables the byte i positions above the access address
   always_comb begin
      rdata = 64'd0;
      wwin  = 64'd0;
      be    = 8'h00;
      case (size)
         SZ_BYTE: begin
            rdata        = {{56{rwin[63]}}, rwin[63:56]};
            wwin[63:56]  = wdata[7:0];
            be           = 8'h01;
         end
         SZ_WORD: begin
            rdata        = {32'd0, rwin[63:32]};
            wwin[63:32]  = wdata[31:0];
            be           = 8'h0F;
         end
         SZ_DOUBLE: begin
            rdata        = rwin;
            wwin         = wdata;
            be           = 8'hFF;
         end
         default: begin
            rdata = 64'd0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// then a single-cycle response strobe with load data or error.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_byte,
   input  logic              req_double,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [63:0]       req_wdata,
   output logic              rsp_valid,
   output logic [63:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q, err_q;
   size_e             size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       wdata_q;
   logic [63:0]       rdata_q, rdata_d;
   logic              rerr_q, rerr_d;

   logic [7:0]        mem [Depth];

   size_e             req_size;
   logic [ADDR_W:0]   end_addr;
   logic              in_err;
   logic              accept;
   logic              in_idle;
   logic              cur_write, cur_err;
   size_e             cur_size;
   logic [ADDR_W-1:0] cur_addr;
   logic [63:0]       cur_wdata;
   logic              enter_resp, commit_wr;
   logic [63:0]       rwin, wwin, lane_rdata;
   logic [7:0]        be;

   always_comb begin
      req_size = SZ_WORD;
      if (req_byte)        req_size = SZ_BYTE;
      else if (req_double) req_size = SZ_DOUBLE;
   end

   assign end_addr = {1'b0, req_addr} + (ADDR_W + 1)'(size_bytes(req_size));
   assign in_err   = (req_byte & req_double)
                   | ~is_aligned(req_size, req_addr[2:0])
                   | (end_addr > (ADDR_W + 1)'(Depth));

   // Ready is forced low while reset is asserted
   assign req_ready = (state_q == IDLE) & rst_n;
   assign accept    = req_valid & req_ready;
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = rerr_q;

   // In IDLE the live request is used so a zero-wait access can commit on accept
   assign in_idle   = (state_q == IDLE);
   assign cur_write = in_idle ? req_write : write_q;
   assign cur_err   = in_idle ? in_err    : err_q;
   assign cur_size  = in_idle ? req_size  : size_q;
   assign cur_addr  = in_idle ? req_addr  : addr_q;
   assign cur_wdata = in_idle ? req_wdata : wdata_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign enter_resp = (state_d == RESP) && (state_q != RESP);
   assign commit_wr  = enter_resp & cur_write & ~cur_err;

   always_comb begin
      rwin = 64'd0;
      for (int unsigned i = 0; i < 8; i++) begin
         rwin[63 - 8 * i -: 8] = mem[cur_addr + ADDR_W'(i)];
      end
   end

   dmem_lane_align u_lane_align (
      .size  (cur_size),
      .rwin  (rwin),
      .wdata (cur_wdata),
      .rdata (lane_rdata),
      .wwin  (wwin),
      .be    (be)
   );

   always_comb begin
      rdata_d = rdata_q;
      rerr_d  = rerr_q;
      if (enter_resp) begin
         rdata_d = (cur_write | cur_err) ? 64'd0 : lane_rdata;
         rerr_d  = cur_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= SZ_WORD;
         addr_q  <= '0;
         wdata_q <= 64'd0;
         rdata_q <= 64'd0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
         if (accept) begin
            write_q <= req_write;
            err_q   <= in_err;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (commit_wr) begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (be[i]) mem[cur_addr + ADDR_W'(i)] <= wwin[63 - 8 * i -: 8];
         end
      end
   end

endmodule
